// File: rtl/spi_seq.sv
// spi_seq: runs one SPI transaction on the spi_if bus port. It sends the settings word,
// streams framed TX bytes into the write FIFO and drains received bytes to a ready/valid port.
module spi_seq #(
    parameter int CNT_W      = 8,
    parameter int POLL_LIMIT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [10:0]      req_cfg,
    input  logic [CNT_W-1:0] req_len,
    input  logic             req_rx,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             done,
    output logic             done_short,
    output logic             busy,
    output logic [10:0]      sif_din,
    output logic             sif_cmd,
    output logic             sif_wr,
    output logic             sif_rd,
    input  logic [8:0]       sif_dout,
    input  logic             sif_ack
);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CFG   = 4'd1;
    localparam logic [3:0] S_CFG_W = 4'd2;
    localparam logic [3:0] S_WR    = 4'd3;
    localparam logic [3:0] S_WR_W  = 4'd4;
    localparam logic [3:0] S_RD    = 4'd5;
    localparam logic [3:0] S_RD_W  = 4'd6;
    localparam logic [3:0] S_DRAIN = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [10:0]      cfg_q, cfg_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             rx_q, rx_d;
    logic [CNT_W:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W:0]   rx_cnt_q, rx_cnt_d;
    logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             done_short_q, done_short_d;

    logic [CNT_W:0]   len_ext_s, len_p1_s;
    logic             wr_first_s, wr_last_s, drain_s;
    logic             cmd_s, wr_s, rd_s, tx_ready_s;
    logic [10:0]      din_s;

    // Counters are one bit wider than len so a full 2^CNT_W byte transfer does not wrap.
    assign len_ext_s  = {1'b0, len_q};
    assign len_p1_s   = len_ext_s + (CNT_W+1)'(1);
    assign wr_first_s = (wr_cnt_q == (CNT_W+1)'(0));
    assign wr_last_s  = (wr_cnt_q == len_ext_s);
    assign drain_s    = (wr_cnt_q == len_p1_s);

    // Next-state, strobe and datapath decode.
    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        len_d        = len_q;
        rx_d         = rx_q;
        wr_cnt_d     = wr_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        rx_data_d    = rx_data_q;
        done_short_d = done_short_q;
        cmd_s        = 1'b0;
        wr_s         = 1'b0;
        rd_s         = 1'b0;
        tx_ready_s   = 1'b0;
        din_s        = 11'd0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cfg_d      = req_cfg;
                    len_d      = req_len;
                    rx_d       = req_rx;
                    wr_cnt_d   = (CNT_W+1)'(0);
                    rx_cnt_d   = (CNT_W+1)'(0);
                    poll_cnt_d = PW'(0);
                    state_d    = S_CFG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                cmd_s   = 1'b1;
                din_s   = cfg_q;
                state_d = S_CFG_W;
            end
            S_CFG_W: begin
                if (sif_ack) begin
                    state_d = S_WR;
                end else begin
                    state_d = S_CFG_W;
                end
            end
            S_WR: begin
                if (tx_valid) begin
                    wr_s    = 1'b1;
                    din_s   = {rx_q, wr_last_s, wr_first_s, tx_data};
                    state_d = S_WR_W;
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR_W: begin
                // A missing ack means the write FIFO was full: the same byte is sent again.
                if (sif_ack) begin
                    tx_ready_s = 1'b1;
                    wr_cnt_d   = wr_cnt_q + (CNT_W+1)'(1);
                    if (rx_q && (rx_cnt_q <= len_ext_s) && !rx_valid_q) begin
                        state_d = S_RD;
                    end else if (!wr_last_s) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                rd_s = 1'b1;
                if (!sif_dout[8]) begin
                    rx_data_d  = sif_dout[7:0];
                    rx_valid_d = 1'b1;
                    rx_cnt_d   = rx_cnt_q + (CNT_W+1)'(1);
                    poll_cnt_d = PW'(0);
                end else if (drain_s) begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                end else begin
                    poll_cnt_d = poll_cnt_q;
                end
                state_d = S_RD_W;
            end
            S_RD_W: begin
                if (drain_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WR;
                end
            end
            S_DRAIN: begin
                // The final byte may never reach the read FIFO, so polling is bounded.
                if (!rx_q || (rx_cnt_q == len_p1_s)) begin
                    state_d = S_DONE;
                end else if (poll_cnt_q == POLL_MAX) begin
                    done_short_d = 1'b1;
                    state_d      = S_DONE;
                end else if (!rx_valid_q) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                done_short_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cfg_q        <= 11'd0;
            len_q        <= '0;
            rx_q         <= 1'b0;
            wr_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            poll_cnt_q   <= '0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            done_short_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            len_q        <= len_d;
            rx_q         <= rx_d;
            wr_cnt_q     <= wr_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            done_short_q <= done_short_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign done_short = done_short_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign sif_din    = din_s;
    assign sif_cmd    = cmd_s & ~rst;
    assign sif_wr     = wr_s & ~rst;
    assign sif_rd     = rd_s & ~rst;
    assign tx_ready   = tx_ready_s & ~rst;
endmodule

// File: tb/tb_spi_seq.sv
// Directed bench for spi_seq with a small spi_if model (ack, write-full stalls, scripted reads).
module tb_spi_seq;
    localparam int CNT_W      = 8;
    localparam int POLL_LIMIT = 1023;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_rx;
    logic [10:0]      req_cfg;
    logic [CNT_W-1:0] req_len;
    logic [7:0]       tx_data, rx_data;
    logic             tx_valid, tx_ready, rx_valid, rx_ready;
    logic             done, done_short, busy;
    logic [10:0]      sif_din;
    logic             sif_cmd, sif_wr, sif_rd, sif_ack;
    logic [8:0]       sif_dout;

    spi_seq #(.CNT_W(CNT_W), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cfg(req_cfg),
        .req_len(req_len), .req_rx(req_rx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .done(done), .done_short(done_short), .busy(busy),
        .sif_din(sif_din), .sif_cmd(sif_cmd), .sif_wr(sif_wr), .sif_rd(sif_rd),
        .sif_dout(sif_dout), .sif_ack(sif_ack)
    );

    always #5 clk = ~clk;

    // spi_if model and TX source
    logic [7:0] tx_mem [16];
    logic [8:0] rd_mem [16];
    int         rd_len, nack_init;
    int         tx_idx, rd_idx, nack_left;
    logic       mon_clr;

    assign tx_data  = tx_mem[tx_idx[3:0]];
    assign sif_dout = (rd_idx < rd_len) ? rd_mem[rd_idx[3:0]] : 9'h100;

    always @(posedge clk) begin
        if (mon_clr) begin
            tx_idx    <= 0;
            rd_idx    <= 0;
            nack_left <= nack_init;
            sif_ack   <= 1'b0;
        end else begin
            sif_ack <= sif_cmd | sif_rd;
            if (sif_wr) begin
                if (nack_left > 0) nack_left <= nack_left - 1;
                else               sif_ack   <= 1'b1;
            end
            if (tx_ready) tx_idx <= tx_idx + 1;
            if (sif_rd)   rd_idx <= rd_idx + 1;
        end
    end

    // Observation on the falling edge
    int cmd_n, wr_n, rd_n, txr_n, done_n, excl_err, rd_busy_err, empty_run, wr_at_txr;
    logic [10:0] cmd_din;
    logic        short_seen;
    int          wr_words[$], rx_bytes[$], exp_wr[$], exp_rx[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            cmd_n <= 0; wr_n <= 0; rd_n <= 0; txr_n <= 0; done_n <= 0;
            excl_err <= 0; rd_busy_err <= 0; empty_run <= 0; wr_at_txr <= 0;
            cmd_din <= 11'd0; short_seen <= 1'b0;
            wr_words.delete();
            rx_bytes.delete();
        end else begin
            if ((int'(sif_cmd) + int'(sif_wr) + int'(sif_rd)) > 1) excl_err <= excl_err + 1;
            if (sif_cmd) begin
                cmd_n   <= cmd_n + 1;
                cmd_din <= sif_din;
            end
            if (sif_wr) begin
                wr_n <= wr_n + 1;
                wr_words.push_back(int'(sif_din));
            end
            if (sif_rd) begin
                rd_n <= rd_n + 1;
                if (rx_valid)    rd_busy_err <= rd_busy_err + 1;
                if (sif_dout[8]) empty_run   <= empty_run + 1;
                else             empty_run   <= 0;
            end
            if (tx_ready) begin
                if (txr_n == 0) wr_at_txr <= wr_n;
                txr_n <= txr_n + 1;
            end
            if (rx_valid && rx_ready) rx_bytes.push_back(int'(rx_data));
            if (done) begin
                done_n     <= done_n + 1;
                short_seen <= done_short;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        tx_mem[0] = b0; tx_mem[1] = b1; tx_mem[2] = b2; tx_mem[3] = b3;
    endtask

    task automatic do_req(input logic [10:0] cfg, input logic [7:0] len, input logic rx);
        req_cfg   = cfg;
        req_len   = len;
        req_rx    = rx;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_n != 0) begin
                seen = 1;
                break;
            end
        end
        check_eq({tag, "_done_in_time"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic check_wr(input string tag);
        check_eq({tag, "_wr_count"}, 32'(wr_words.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_words.size(); i++)
            check_eq($sformatf("%s_wr%0d", tag, i), 32'(wr_words[i]), 32'(exp_wr[i]));
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_rx_count"}, 32'(rx_bytes.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_bytes.size(); i++)
            check_eq($sformatf("%s_rx%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_rx[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, txr_rel;
        rst = 1'b1; req_valid = 1'b0; req_cfg = 11'd0; req_len = 8'd0; req_rx = 1'b0;
        tx_valid = 1'b1; rx_ready = 1'b1; mon_clr = 1'b1;
        rd_len = 0; nack_init = 0;
        set_tx(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        mon_clr = 1'b0;

        // Reset state
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'({done, done_short}), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_strobes", 32'({sif_cmd, sif_wr, sif_rd, tx_ready}), 32'd0);
        check_eq("rst_din", 32'(sif_din), 32'd0);

        // 3-byte write, no RX
        set_tx(8'hA5, 8'h3C, 8'h81, 8'h00);
        rd_len = 0;
        clear_mon();
        do_req(11'h008, 8'd2, 1'b0);
        wait_done("w3", 200);
        check_eq("w3_cmd_n", 32'(cmd_n), 32'd1);
        check_eq("w3_cmd_din", 32'(cmd_din), 32'h008);
        exp_wr = '{32'h1A5, 32'h03C, 32'h281};
        check_wr("w3");
        check_eq("w3_tx_ready_n", 32'(txr_n), 32'd3);
        check_eq("w3_done_n", 32'(done_n), 32'd1);
        check_eq("w3_short", 32'(short_seen), 32'd0);
        check_eq("w3_rd_n", 32'(rd_n), 32'd0);
        check_eq("w3_excl", 32'(excl_err), 32'd0);

        // Write FIFO full twice
        set_tx(8'h55, 8'h00, 8'h00, 8'h00);
        nack_init = 2;
        clear_mon();
        do_req(11'h008, 8'd0, 1'b0);
        wait_done("full", 200);
        nack_init = 0;
        exp_wr = '{32'h355, 32'h355, 32'h355};
        check_wr("full");
        check_eq("full_tx_ready_n", 32'(txr_n), 32'd1);
        check_eq("full_wr_before_txr", 32'(wr_at_txr), 32'd3);

        // len=3 with RX interleaved with empties
        set_tx(8'h01, 8'h02, 8'h03, 8'h04);
        rd_mem[0] = 9'h011; rd_mem[1] = 9'h100; rd_mem[2] = 9'h022;
        rd_mem[3] = 9'h100; rd_mem[4] = 9'h033; rd_mem[5] = 9'h044;
        rd_len = 6;
        clear_mon();
        do_req(11'h00B, 8'd3, 1'b1);
        wait_done("rx4", 400);
        exp_rx = '{32'h11, 32'h22, 32'h33, 32'h44};
        check_rx("rx4");
        exp_wr = '{32'h501, 32'h402, 32'h403, 32'h604};
        check_wr("rx4");
        check_eq("rx4_short", 32'(short_seen), 32'd0);
        check_eq("rx4_excl", 32'(excl_err), 32'd0);

        // Last RX byte never arrives: bounded polling
        rd_mem[0] = 9'h100; rd_mem[1] = 9'h011; rd_mem[2] = 9'h022; rd_mem[3] = 9'h033;
        rd_len = 4;
        clear_mon();
        do_req(11'h008, 8'd3, 1'b1);
        wait_done("poll", 5000);
        exp_rx = '{32'h11, 32'h22, 32'h33};
        check_rx("poll");
        check_eq("poll_empty_run", 32'(empty_run), 32'(POLL_LIMIT));
        check_eq("poll_done_n", 32'(done_n), 32'd1);
        check_eq("poll_short", 32'(short_seen), 32'd1);

        // Consumer stalls after the first RX byte
        rd_mem[0] = 9'h011; rd_mem[1] = 9'h022; rd_mem[2] = 9'h033; rd_mem[3] = 9'h044;
        rd_len = 4;
        rx_ready = 1'b0;
        clear_mon();
        do_req(11'h008, 8'd3, 1'b1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rx_valid) begin
                found = 1;
                break;
            end
        end
        check_eq("stall_first_rx", 32'(found), 32'd1);
        repeat (50) tick();
        txr_rel = txr_n;
        rx_ready = 1'b1;
        wait_done("stall", 400);
        check_eq("stall_writes_continue", 32'(txr_rel), 32'd4);
        check_eq("stall_rd_while_valid", 32'(rd_busy_err), 32'd0);
        exp_rx = '{32'h11, 32'h22, 32'h33, 32'h44};
        check_rx("stall");
        check_eq("stall_short", 32'(short_seen), 32'd0);

        // Reset while waiting for a write ack
        set_tx(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        rd_len = 0;
        clear_mon();
        do_req(11'h008, 8'd3, 1'b0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sif_wr) begin
                found = 1;
                break;
            end
        end
        check_eq("abort_wr_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("abort_req_ready", 32'(req_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_strobes", 32'({sif_cmd, sif_wr, sif_rd}), 32'd0);
        tick();
        set_tx(8'h12, 8'h34, 8'h00, 8'h00);
        clear_mon();
        do_req(11'h008, 8'd1, 1'b0);
        wait_done("after_abort", 200);
        exp_wr = '{32'h112, 32'h234};
        check_wr("after_abort");
        check_eq("after_abort_done_n", 32'(done_n), 32'd1);

        // Single byte carries start and stop
        set_tx(8'hFF, 8'h00, 8'h00, 8'h00);
        clear_mon();
        do_req(11'h008, 8'd0, 1'b0);
        wait_done("len0", 200);
        exp_wr = '{32'h3FF};
        check_wr("len0");
        check_eq("len0_done_n", 32'(done_n), 32'd1);
        check_eq("len0_tx_ready_n", 32'(txr_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
